select_pulse_gen: RTL
=====================

# select_pulse_gen

Generates the clean `select_in` strobe that the 2-bit selection counter consumes. It takes a raw, bouncy, asynchronous push-button input and synchronizes and debounces it. It emits exactly one single-cycle `select_pulse` per debounced press, with optional auto-repeat while the button is held. It sits between the board button pin and the selection logic; the counter is clocked or enabled by `select_pulse`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized samples needed to accept a level change (≥2).
- `REPEAT_EN`, 1: 1 enables auto-repeat while held; 0 gives one pulse per press.
- `REPEAT_DELAY`, 50000000: cycles in HELD before the first repeat pulse (≥2).
- `REPEAT_PERIOD`, 20000000: cycles between subsequent repeat pulses (≥2).

Ports:
- `clk`  input  1  system clock; single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `btn_raw`  input  1  asynchronous raw button, active-high.
- `select_pulse`  output  1  one-cycle strobe per accepted press or repeat.
- `btn_level`  output  1  debounced button level.
- `repeat_active`  output  1  high while in the REPEAT state.

## Operation
- `btn_raw` passes through a 2-flop synchronizer, giving `s`. The synchronizer flops reset to 0.
- One shared counter `cnt` is used. Its width is `$clog2` of the largest parameter.
- FSM states: IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE.
  - IDLE: if `s`=1, go to DEB_PRESS with `cnt`=0.
  - DEB_PRESS: if `s`=0, return to IDLE with no pulse. Otherwise `cnt`++. When `s`=1 and `cnt`==DEBOUNCE_CYCLES-1, go to HELD with `cnt`=0, and assert `select_pulse` and `btn_level` on the next cycle.
  - HELD: if `s`=0, go to DEB_RELEASE with `cnt`=0. Otherwise `cnt`++. When REPEAT_EN=1 and `cnt`==REPEAT_DELAY-1, pulse and go to REPEAT with `cnt`=0.
  - REPEAT: if `s`=0, go to DEB_RELEASE. Otherwise `cnt`++. When `cnt`==REPEAT_PERIOD-1, pulse and set `cnt`=0.
  - DEB_RELEASE: if `s`=1, return to HELD with `cnt`=0. This restarts the repeat delay and produces no pulse. Otherwise `cnt`++. When `cnt`==DEBOUNCE_CYCLES-1, go to IDLE and drop `btn_level`.
- `btn_level` is 1 in HELD, REPEAT and DEB_RELEASE, and 0 otherwise.
- `repeat_active` is 1 only in REPEAT.
- All outputs are registered.
- Reset values: `select_pulse`=0, `btn_level`=0, `repeat_active`=0, state IDLE, `cnt`=0, synchronizer 0.

## Timing
- Press latency: with `btn_raw` sampled high at edge 0 and stable, `select_pulse` is high for exactly one cycle at edge 2+DEBOUNCE_CYCLES.
- Release latency: `btn_level` falls at edge 2+DEBOUNCE_CYCLES after the first low sample, with stable input.
- First repeat pulse: REPEAT_DELAY cycles after the press pulse. Later repeat pulses come every REPEAT_PERIOD cycles.
- `select_pulse` is never high on two consecutive cycles, given the parameter minimums.
- Any bounce shorter than DEBOUNCE_CYCLES restarts debouncing and produces no pulse.
- Reset asserted mid-operation clears everything on the next edge; no pulse is emitted during or because of reset.
- Button held through reset deassertion: treated as a fresh press; a pulse occurs 2+DEBOUNCE_CYCLES cycles after the first non-reset edge.

## Structure
- Shared package `select_pkg`:
  - `select_state_t` enum (IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE).
  - Default parameter constants.
- Sub-module `btn_sync`: 2-flop synchronizer with synchronous reset, reusable for other board inputs.
- The FSM and counter live in `select_pulse_gen`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=1.
- Clean press: `btn_raw` 0→1 at edge 10, held 15 cycles, then released → one `select_pulse` at edge 16; `btn_level` rises at 16 and falls 6 cycles after the release edge; no other pulses.
- Bounce rejection: `btn_raw` toggles 1,0,1,1,0 on successive edges, then stays 0 → no pulse, `btn_level` stays 0, state returns to IDLE.
- Auto-repeat: press held for 60 cycles after the first pulse at edge P → pulses at P, P+20, P+28, P+36, P+44, P+52; `repeat_active` is high from P+20 until release.
- Release glitch: in HELD, `btn_raw` goes low for 2 cycles → no IDLE, no pulse, `btn_level` stays 1; the repeat timer restarts.
- REPEAT_EN=0: press held for 100 cycles → exactly one pulse; `repeat_active` stays 0.
- Reset mid-hold: assert `reset` for 1 cycle in REPEAT while the button stays held → all outputs 0 on the next edge; a fresh pulse occurs 6 cycles after `reset` deasserts.

Source files
------------

// File: rtl/select_pkg.sv
// Shared types and default timing constants for the select-button front end.
package select_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        REPEAT,
        DEB_RELEASE
    } select_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_EN       = 1;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 20000000;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous board input, synchronous reset to 0.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/select_pulse_gen.sv
// Debounces a raw push-button and emits one-cycle select strobes, with optional auto-repeat.
module select_pulse_gen
    import select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic select_pulse,
    output logic btn_level,
    output logic repeat_active
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    logic          s;
    select_state_t state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          pulse;

    btn_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (s)
    );

    // A low sample always wins over a terminal count, so a release never emits a pulse.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + CW'(1);
        pulse     = 1'b0;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (s) nxt_state = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!s) begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end else if (cnt == DEB_LAST) begin
                    nxt_state = HELD;
                    nxt_cnt   = '0;
                    pulse     = 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    nxt_state = DEB_RELEASE;
                    nxt_cnt   = '0;
                end else if (REPEAT_EN != 0 && cnt == DLY_LAST) begin
                    nxt_state = REPEAT;
                    nxt_cnt   = '0;
                    pulse     = 1'b1;
                end
            end
            REPEAT: begin
                if (!s) begin
                    nxt_state = DEB_RELEASE;
                    nxt_cnt   = '0;
                end else if (cnt == PER_LAST) begin
                    nxt_cnt = '0;
                    pulse   = 1'b1;
                end
            end
            DEB_RELEASE: begin
                // A bounce back high resumes the hold and restarts the repeat delay.
                if (s) begin
                    nxt_state = HELD;
                    nxt_cnt   = '0;
                end else if (cnt == DEB_LAST) begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            select_pulse  <= 1'b0;
            btn_level     <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            select_pulse  <= pulse;
            btn_level     <= (nxt_state == HELD) || (nxt_state == REPEAT) ||
                             (nxt_state == DEB_RELEASE);
            repeat_active <= (nxt_state == REPEAT);
        end
    end

endmodule
